// File: rtl/vga_sync_gen_pkg.sv
// Shared 640x480@60 timing constants and screen-coordinate type; the overlay
// renderer and font lookup import this package for screen bounds.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Sync windows are inclusive on both ends.
    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_DISPLAY + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam int COORD_W = 10;
    localparam int DIV_W   = 4;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic coord_t wrap_inc(input coord_t v, input coord_t last);
        return (v == last) ? '0 : v + coord_t'(1);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bundle from the sync generator to the overlay/font pipeline.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    // Free-running stream: every signal is valid every clk, there is no
    // backpressure; consumers qualify pixel work with p_tick and video_on.
    logic   p_tick;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   frame_start;
    logic   blink;

    modport master (
        output p_tick,
        output hsync,
        output vsync,
        output video_on,
        output pixel_x,
        output pixel_y,
        output frame_start,
        output blink
    );

    modport slave (
        input p_tick,
        input hsync,
        input vsync,
        input video_on,
        input pixel_x,
        input pixel_y,
        input frame_start,
        input blink
    );

endinterface

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// Divides the system clock down to a one-clk pixel strobe every CLK_DIV clocks.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_p_tick
);
    import vga_timing_pkg::*;

    localparam logic [DIV_W-1:0] L_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             r_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
            r_div <= (r_div == L_LAST) ? '0 : r_div + DIV_W'(1);
        end
    end

    // r_run keeps the strobe low in reset even when CLK_DIV is 1.
    assign o_p_tick = r_run && (r_div == L_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing: pixel counters, registered syncs, frame strobe and
// blink. The blink counter is built only when VGA_BLINK_EN is defined.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
`ifdef VGA_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 30
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    vga_sync_gen_if.master vga
);
    import vga_timing_pkg::*;

    localparam coord_t L_H_LAST   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t L_V_LAST   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t L_H_DISP   = coord_t'(H_DISPLAY);
    localparam coord_t L_V_DISP   = coord_t'(V_DISPLAY);
    localparam coord_t L_HS_START = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t L_HS_END   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t L_VS_START = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t L_VS_END   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic   w_p_tick;
    coord_t r_x;
    coord_t r_y;
    coord_t w_x_next;
    coord_t w_y_next;
    logic   w_frame_end;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_frame_start;
    logic   w_blink;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .o_p_tick (w_p_tick)
    );

    always_comb begin
        w_x_next    = r_x;
        w_y_next    = r_y;
        w_frame_end = 1'b0;
        if (w_p_tick) begin
            w_x_next = wrap_inc(r_x, L_H_LAST);
            if (r_x == L_H_LAST) begin
                w_y_next    = wrap_inc(r_y, L_V_LAST);
                w_frame_end = (r_y == L_V_LAST);
            end
        end
    end

    // Syncs are decoded from the next position so they flip on the same edge
    // as the counters and leave the flops glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_hsync       <= !in_window(w_x_next, L_HS_START, L_HS_END);
            r_vsync       <= !in_window(w_y_next, L_VS_START, L_VS_END);
            r_frame_start <= w_frame_end;
        end
    end

`ifdef VGA_BLINK_EN
    localparam logic [4:0] L_BLINK_LAST = 5'(BLINK_FRAMES - 1);

    logic [4:0] r_frame_cnt;
    logic       r_blink;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_frame_start) begin
            if (r_frame_cnt == L_BLINK_LAST) begin
                r_frame_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_frame_cnt <= r_frame_cnt + 5'd1;
            end
        end
    end

    assign w_blink = r_blink;
`else
    assign w_blink = 1'b0;
`endif

    assign vga.p_tick      = w_p_tick;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.video_on    = (r_x < L_H_DISP) && (r_y < L_V_DISP);
    assign vga.pixel_x     = r_x;
    assign vga.pixel_y     = r_y;
    assign vga.frame_start = r_frame_start;
    assign vga.blink       = w_blink;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a shrunk-timing instance run for many frames plus a
// default-timing instance run for a few lines, both against a closed-form model.
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    typedef struct packed {
        int d; int hd; int hf; int hs; int hb;
        int vd; int vf; int vs; int vb; int bf;
    } cfg_t;

    typedef struct packed {
        logic p_tick; logic hsync; logic vsync; logic video_on;
        logic frame_start; logic blink; int x; int y;
    } exp_t;

    localparam cfg_t CFG_A = '{d:3, hd:20, hf:4, hs:6, hb:5, vd:12, vf:3, vs:2, vb:4, bf:3};
    localparam cfg_t CFG_B = '{d:4, hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33, bf:30};

`ifdef VGA_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    // Hand-computed figures for CFG_A: 35 pixels x 21 lines, 3 clks per pixel.
    localparam int A_HT         = 35;
    localparam int A_VT         = 21;
    localparam int A_FRAME_CLKS = 2205;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   k     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();

    vga_sync_gen #(
        .CLK_DIV   (3),
        .H_DISPLAY (20),
        .H_FRONT   (4),
        .H_SYNC    (6),
        .H_BACK    (5),
        .V_DISPLAY (12),
        .V_FRONT   (3),
        .V_SYNC    (2),
        .V_BACK    (4)
`ifdef VGA_BLINK_EN
        ,
        .BLINK_FRAMES (3)
`endif
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (if_a)
    );

    vga_sync_gen u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (if_b)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    // k = number of clk edges since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else        k <= k + 1;
    end

    // ---------------- behavioural model ----------------
    function automatic exp_t model(input int kk, input cfg_t c);
        exp_t e;
        int ht, vt, fclk, ticks, fs_seen;
        ht    = c.hd + c.hf + c.hs + c.hb;
        vt    = c.vd + c.vf + c.vs + c.vb;
        fclk  = ht * vt * c.d;
        ticks = kk / c.d;
        e.x = ticks % ht;
        e.y = (ticks / ht) % vt;
        e.p_tick      = ((kk % c.d) == (c.d - 1));
        e.hsync       = !((e.x >= c.hd + c.hf) && (e.x < c.hd + c.hf + c.hs));
        e.vsync       = !((e.y >= c.vd + c.vf) && (e.y < c.vd + c.vf + c.vs));
        e.video_on    = (e.x < c.hd) && (e.y < c.vd);
        e.frame_start = (kk > 0) && ((kk % fclk) == 0);
        fs_seen       = (kk > 0) ? (kk - 1) / fclk : 0;
        e.blink       = BLINK_EN && (((fs_seen / c.bf) % 2) == 1);
        return e;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_out(input string tag, input exp_t e,
                             input logic pt, input logic hs, input logic vs, input logic von,
                             input logic fs, input logic bl, input coord_t x, input coord_t y);
        n_tests++;
        if (pt !== e.p_tick || hs !== e.hsync || vs !== e.vsync || von !== e.video_on ||
            fs !== e.frame_start || bl !== e.blink || x !== coord_t'(e.x) || y !== coord_t'(e.y)) begin
            n_fail++;
            $display("FAIL %s k=%0d got pt=%b x=%0d y=%0d hs=%b vs=%b von=%b fs=%b bl=%b required pt=%b x=%0d y=%0d hs=%b vs=%b von=%b fs=%b bl=%b",
                     tag, k, pt, x, y, hs, vs, von, fs, bl,
                     e.p_tick, e.x, e.y, e.hsync, e.vsync, e.video_on, e.frame_start, e.blink);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got %0d required %0d", tag, got, req);
        end
    endtask

    always @(negedge clk) begin
        check_out("a_cycle", model(k, CFG_A), if_a.p_tick, if_a.hsync, if_a.vsync, if_a.video_on,
                  if_a.frame_start, if_a.blink, if_a.pixel_x, if_a.pixel_y);
        check_out("b_cycle", model(k, CFG_B), if_b.p_tick, if_b.hsync, if_b.vsync, if_b.video_on,
                  if_b.frame_start, if_b.blink, if_b.pixel_x, if_b.pixel_y);
    end

    // ---------------- measurement monitors (first run after release) ----------------
    int     a_first_x_k = -1, a_hs_lo_x = -1, a_hs_hi_x = -1, a_hs_ticks = 0;
    int     a_vs_first = -1, a_vs_last = -1, a_von_ticks = 0, a_ywrap = 0, a_toggles = 0;
    int     a_wrap_k[$], a_fs_k[$], a_von_frame[$];
    coord_t a_prev_x = '0, a_prev_y = '0;
    logic   a_prev_hs = 1'b1, a_prev_bl = 1'b0;

    int     b_first_x_k = -1, b_hs_lo_x = -1, b_hs_hi_x = -1, b_hs_ticks = 0, b_blink_hi = 0;
    int     b_wrap_k[$];
    coord_t b_prev_x = '0;
    logic   b_prev_hs = 1'b1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (a_first_x_k < 0 && if_a.pixel_x != 0) a_first_x_k = k;
            if (if_a.pixel_x == 0 && a_prev_x == coord_t'(A_HT - 1)) a_wrap_k.push_back(k);
            if (a_prev_hs && !if_a.hsync && a_hs_lo_x < 0) a_hs_lo_x = int'(if_a.pixel_x);
            if (!a_prev_hs && if_a.hsync && a_hs_lo_x >= 0 && a_hs_hi_x < 0) a_hs_hi_x = int'(if_a.pixel_x);
            if (!if_a.hsync && if_a.p_tick && a_hs_lo_x >= 0 && a_hs_hi_x < 0) a_hs_ticks++;
            if (!if_a.vsync) begin
                if (a_vs_first < 0) a_vs_first = int'(if_a.pixel_y);
                a_vs_last = int'(if_a.pixel_y);
            end
            if (if_a.frame_start) begin
                a_fs_k.push_back(k);
                a_von_frame.push_back(a_von_ticks);
                a_von_ticks = 0;
            end
            if (if_a.p_tick && if_a.video_on) a_von_ticks++;
            if (if_a.pixel_y == 0 && a_prev_y == coord_t'(A_VT - 1)) a_ywrap++;
            if (if_a.blink != a_prev_bl) a_toggles++;
            a_prev_x  = if_a.pixel_x;
            a_prev_y  = if_a.pixel_y;
            a_prev_hs = if_a.hsync;
            a_prev_bl = if_a.blink;

            if (b_first_x_k < 0 && if_b.pixel_x != 0) b_first_x_k = k;
            if (if_b.pixel_x == 0 && b_prev_x == coord_t'(799)) b_wrap_k.push_back(k);
            if (b_prev_hs && !if_b.hsync && b_hs_lo_x < 0) b_hs_lo_x = int'(if_b.pixel_x);
            if (!b_prev_hs && if_b.hsync && b_hs_lo_x >= 0 && b_hs_hi_x < 0) b_hs_hi_x = int'(if_b.pixel_x);
            if (!if_b.hsync && if_b.p_tick && b_hs_lo_x >= 0 && b_hs_hi_x < 0) b_hs_ticks++;
            if (if_b.blink) b_blink_hi++;
            b_prev_x  = if_b.pixel_x;
            b_prev_hs = if_b.hsync;
        end
    end

    // ---------------- driver ----------------
    task automatic pulse_reset_midframe();
        exp_t rst_exp;
        rst_exp = '{p_tick:1'b0, hsync:1'b1, vsync:1'b1, video_on:1'b1,
                    frame_start:1'b0, blink:1'b0, x:0, y:0};
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_out("a_async_rst", rst_exp, if_a.p_tick, if_a.hsync, if_a.vsync, if_a.video_on,
                  if_a.frame_start, if_a.blink, if_a.pixel_x, if_a.pixel_y);
        check_out("b_async_rst", rst_exp, if_b.p_tick, if_b.hsync, if_b.vsync, if_b.video_on,
                  if_b.frame_start, if_b.blink, if_b.pixel_x, if_b.pixel_y);
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        mon_en = 1'b1;

        repeat (8 * A_FRAME_CLKS + 20) @(posedge clk);
        #1 mon_en = 1'b0;

        chk_int("a_first_tick_edge", a_first_x_k, 3);
        chk_int("a_first_wrap_k", (a_wrap_k.size() > 0) ? a_wrap_k[0] : -1, 105);
        chk_int("a_line_period", (a_wrap_k.size() > 1) ? a_wrap_k[1] - a_wrap_k[0] : -1, 105);
        chk_int("a_hsync_low_x", a_hs_lo_x, 24);
        chk_int("a_hsync_high_x", a_hs_hi_x, 30);
        chk_int("a_hsync_ticks", a_hs_ticks, 6);
        chk_int("a_vsync_first_line", a_vs_first, 15);
        chk_int("a_vsync_last_line", a_vs_last, 16);
        chk_int("a_frame_starts", a_fs_k.size(), 8);
        chk_int("a_first_frame_k", (a_fs_k.size() > 0) ? a_fs_k[0] : -1, A_FRAME_CLKS);
        chk_int("a_frame_spacing", (a_fs_k.size() > 1) ? a_fs_k[1] - a_fs_k[0] : -1, A_FRAME_CLKS);
        chk_int("a_video_ticks_f0", (a_von_frame.size() > 0) ? a_von_frame[0] : -1, 240);
        chk_int("a_video_ticks_f1", (a_von_frame.size() > 1) ? a_von_frame[1] : -1, 240);
        chk_int("a_y_wraps", a_ywrap, 8);
        chk_int("a_blink_toggles", a_toggles, BLINK_EN ? 2 : 0);
        chk_int("b_first_tick_edge", b_first_x_k, 4);
        chk_int("b_line_period", (b_wrap_k.size() > 1) ? b_wrap_k[1] - b_wrap_k[0] : -1, 3200);
        chk_int("b_hsync_low_x", b_hs_lo_x, 656);
        chk_int("b_hsync_high_x", b_hs_hi_x, 752);
        chk_int("b_hsync_ticks", b_hs_ticks, 96);
        chk_int("b_blink_high", b_blink_hi, 0);

        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, A_FRAME_CLKS)) @(posedge clk);
            pulse_reset_midframe();
            repeat (A_FRAME_CLKS + $urandom_range(0, 500)) @(posedge clk);
        end

        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
